// File: rtl/mcu_pkg.sv
// Shared constants, condition encodings and FSM state type for the micro-sequencer.
package mcu_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned OPC_W  = 6;
  localparam int unsigned CNT_W  = 16;

  localparam logic [ADDR_W-1:0] FETCH_ADDR    = 16'h0000;
  localparam logic [ADDR_W-1:0] DISPATCH_BASE = 16'h0400;
  localparam logic [ADDR_W-1:0] HLT_ADDR      = 16'h07E0;

  localparam logic [1:0] COND_Z      = 2'd0;
  localparam logic [1:0] COND_C      = 2'd1;
  localparam logic [1:0] COND_N      = 2'd2;
  localparam logic [1:0] COND_ALWAYS = 2'd3;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STEP_WAIT = 2'd1,
    HALT      = 2'd2
  } seq_state_t;

  // Each opcode owns a 16-word microroutine slot above DISPATCH_BASE.
  function automatic logic [ADDR_W-1:0] dispatch_target(input logic [OPC_W-1:0] opc);
    return DISPATCH_BASE + ADDR_W'({opc, 4'b0000});
  endfunction

endpackage

// File: rtl/mpc_sequencer_if.sv
// Control-store / sequencing-control bus between the control unit and the sequencer.
interface mpc_sequencer_if;
  import mcu_pkg::*;

  logic [ADDR_W-1:0] next_addr;
  logic              dispatch;
  logic [OPC_W-1:0]  opcode;
  logic              br_en;
  logic [1:0]        br_sel;
  logic              flag_z;
  logic              flag_c;
  logic              flag_n;
  logic              stall;
  logic              step_mode;
  logic              step_req;
  logic              run_req;
  logic [ADDR_W-1:0] mpc_out;
  logic              halted;
  logic              instr_done;
  logic [CNT_W-1:0]  ucycle_cnt;

  modport master (
    output next_addr, dispatch, opcode, br_en, br_sel,
    output flag_z, flag_c, flag_n,
    output stall, step_mode, step_req, run_req,
    input  mpc_out, halted, instr_done, ucycle_cnt
  );

  modport slave (
    input  next_addr, dispatch, opcode, br_en, br_sel,
    input  flag_z, flag_c, flag_n,
    input  stall, step_mode, step_req, run_req,
    output mpc_out, halted, instr_done, ucycle_cnt
  );

endinterface

// File: rtl/mpc_next_sel.sv
// Combinational next-microaddress mux with branch-condition evaluation.
module mpc_next_sel
  import mcu_pkg::*;
(
  input  logic [ADDR_W-1:0] mpc,
  input  logic [ADDR_W-1:0] next_addr,
  input  logic              dispatch,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              br_en,
  input  logic [1:0]        br_sel,
  input  logic              flag_z,
  input  logic              flag_c,
  input  logic              flag_n,
  output logic [ADDR_W-1:0] target_c
);

  logic cond_c;

  // Select the flag named by br_sel.
  always_comb begin
    cond_c = 1'b0;
    case (br_sel)
      COND_Z:      cond_c = flag_z;
      COND_C:      cond_c = flag_c;
      COND_N:      cond_c = flag_n;
      COND_ALWAYS: cond_c = 1'b1;
      default:     cond_c = 1'b0;
    endcase
  end

  // Dispatch beats branch; a failed branch falls through to mpc+1 (wraps).
  always_comb begin
    target_c = next_addr;
    if (dispatch) begin
      target_c = dispatch_target(opcode);
    end else if (br_en && !cond_c) begin
      target_c = mpc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/mpc_sequencer.sv
// Micro-program counter: run/step/halt FSM, MPC register and microword counter.
module mpc_sequencer
  import mcu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  mpc_sequencer_if.slave bus
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] mpc_q, mpc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              halted_q, halted_d;
  logic              done_q, done_d;
  logic              advance_c;
  logic [ADDR_W-1:0] target_c;

  mpc_next_sel u_next_sel (
    .mpc       (mpc_q),
    .next_addr (bus.next_addr),
    .dispatch  (bus.dispatch),
    .opcode    (bus.opcode),
    .br_en     (bus.br_en),
    .br_sel    (bus.br_sel),
    .flag_z    (bus.flag_z),
    .flag_c    (bus.flag_c),
    .flag_n    (bus.flag_n),
    .target_c  (target_c)
  );

  // State, MPC, counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      mpc_q    <= FETCH_ADDR;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mpc_q    <= mpc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      done_q   <= done_d;
    end
  end

  // Next state and register updates; step_mode is checked before any advance.
  always_comb begin
    state_d   = state_q;
    mpc_d     = mpc_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    advance_c = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.step_mode) begin
          state_d = STEP_WAIT;
        end else if (!bus.stall) begin
          advance_c = 1'b1;
        end
      end
      STEP_WAIT: begin
        if (!bus.step_mode) begin
          state_d = RUN;
        end else if (bus.step_req && !bus.stall) begin
          advance_c = 1'b1;
        end
      end
      HALT: begin
        if (bus.run_req) begin
          state_d = RUN;
          mpc_d   = FETCH_ADDR;
          done_d  = (mpc_q != FETCH_ADDR);
        end
      end
      default: state_d = RUN;
    endcase

    if (advance_c) begin
      mpc_d  = target_c;
      cnt_d  = cnt_q + CNT_W'(1);
      done_d = (target_c == FETCH_ADDR) && (mpc_q != FETCH_ADDR);
      if (target_c == HLT_ADDR) begin
        state_d = HALT;
      end
    end

    halted_d = (state_d == HALT);
  end

  assign bus.mpc_out    = mpc_q;
  assign bus.halted     = halted_q;
  assign bus.instr_done = done_q;
  assign bus.ucycle_cnt = cnt_q;

endmodule

// File: tb/tb_mpc_sequencer.sv
// Scoreboard bench for mpc_sequencer: table-driven cycles, expected state queued per cycle.
module tb_mpc_sequencer;
  import mcu_pkg::*;

  typedef struct packed {
    logic [15:0] mpc;
    logic [15:0] cnt;
    logic        halted;
    logic        done;
  } obs_t;

  // One clock cycle of stimulus plus the expected outcome after its edge.
  typedef struct packed {
    logic [15:0] na;
    logic        disp;
    logic [5:0]  opc;
    logic        be;
    logic [1:0]  sel;
    logic [2:0]  zcn;
    logic        stall;
    logic        smode;
    logic        sreq;
    logic        run;
    logic [15:0] e_mpc;
    logic        e_adv;
    logic        e_halt;
    logic        e_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  logic [15:0] exp_cnt = '0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  mpc_sequencer_if bus();

  mpc_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic obs_t observe();
    return {bus.mpc_out, bus.ucycle_cnt, bus.halted, bus.instr_done};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("mpc=%h cnt=%0d halted=%b done=%b", o.mpc, o.cnt, o.halted, o.done);
  endfunction

  task automatic apply(input vec_t v);
    bus.next_addr = v.na;
    bus.dispatch  = v.disp;
    bus.opcode    = v.opc;
    bus.br_en     = v.be;
    bus.br_sel    = v.sel;
    bus.flag_z    = v.zcn[2];
    bus.flag_c    = v.zcn[1];
    bus.flag_n    = v.zcn[0];
    bus.stall     = v.stall;
    bus.step_mode = v.smode;
    bus.step_req  = v.sreq;
    bus.run_req   = v.run;
  endtask

  task automatic push_exp(input vec_t v);
    if (v.e_adv) exp_cnt = exp_cnt + 16'd1;
    exp_q.push_back({v.e_mpc, exp_cnt, v.e_halt, v.e_done});
  endtask

  task automatic test_reset();
    obs_t got, e;
    rst_n = 1'b0;
    apply('0);
    exp_cnt = '0;
    #12;
    exp_q.push_back({FETCH_ADDR, 16'd0, 1'b0, 1'b0});
    got = observe();
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL reset: got %s, expected %s", fmt(got), fmt(e));
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_seq_dispatch();
    obs_t got, e;
    vec_t v [2] = '{
      '{16'h0001, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0},
      '{16'h0000, 1'b1, 6'd1, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0410, 1'b1, 1'b0, 1'b0}
    };
    for (int i = 0; i < 2; i++) begin
      apply(v[i]);
      push_exp(v[i]);
      @(posedge clk); #1;
      got = observe();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL seq_dispatch[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_branch();
    obs_t got, e;
    vec_t v [13] = '{
      '{16'h0540, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0540, 1'b1, 1'b0, 1'b0},
      '{16'h0570, 1'b0, 6'd0, 1'b1, 2'd0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0570, 1'b1, 1'b0, 1'b0},
      '{16'h0540, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0540, 1'b1, 1'b0, 1'b0},
      '{16'h0570, 1'b0, 6'd0, 1'b1, 2'd0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0541, 1'b1, 1'b0, 1'b0},
      '{16'h0600, 1'b0, 6'd0, 1'b1, 2'd1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0600, 1'b1, 1'b0, 1'b0},
      '{16'h0700, 1'b0, 6'd0, 1'b1, 2'd1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0601, 1'b1, 1'b0, 1'b0},
      '{16'h0650, 1'b0, 6'd0, 1'b1, 2'd2, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0650, 1'b1, 1'b0, 1'b0},
      '{16'h0700, 1'b0, 6'd0, 1'b1, 2'd2, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0651, 1'b1, 1'b0, 1'b0},
      '{16'hFFFF, 1'b0, 6'd0, 1'b1, 2'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0},
      '{16'h1234, 1'b0, 6'd0, 1'b1, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
      '{16'h0000, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0},
      '{16'h0123, 1'b1, 6'd3, 1'b1, 2'd3, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0430, 1'b1, 1'b0, 1'b0},
      '{16'h0000, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1}
    };
    for (int i = 0; i < 13; i++) begin
      apply(v[i]);
      push_exp(v[i]);
      @(posedge clk); #1;
      got = observe();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL branch[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_halt();
    obs_t got, e;
    vec_t v [6] = '{
      '{16'h0000, 1'b1, 6'd62, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h07E0, 1'b1, 1'b1, 1'b0},
      '{16'h1111, 1'b1, 6'd5,  1'b1, 2'd3, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 16'h07E0, 1'b0, 1'b1, 1'b0},
      '{16'h2222, 1'b0, 6'd9,  1'b1, 2'd0, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 16'h07E0, 1'b0, 1'b1, 1'b0},
      '{16'h0000, 1'b1, 6'd0,  1'b0, 2'd1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 16'h07E0, 1'b0, 1'b1, 1'b0},
      '{16'h3333, 1'b0, 6'd0,  1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1},
      '{16'h0000, 1'b0, 6'd0,  1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0}
    };
    for (int i = 0; i < 6; i++) begin
      apply(v[i]);
      push_exp(v[i]);
      @(posedge clk); #1;
      got = observe();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL halt[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_stall();
    obs_t got, e;
    vec_t v [6] = '{
      '{16'h0000, 1'b1, 6'd2, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0420, 1'b1, 1'b0, 1'b0},
      '{16'h0421, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0421, 1'b1, 1'b0, 1'b0},
      '{16'h0422, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0421, 1'b0, 1'b0, 1'b0},
      '{16'h0422, 1'b1, 6'd7, 1'b0, 2'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0421, 1'b0, 1'b0, 1'b0},
      '{16'h0422, 1'b0, 6'd0, 1'b1, 2'd3, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0421, 1'b0, 1'b0, 1'b0},
      '{16'h0422, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0422, 1'b1, 1'b0, 1'b0}
    };
    for (int i = 0; i < 6; i++) begin
      apply(v[i]);
      push_exp(v[i]);
      @(posedge clk); #1;
      got = observe();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL stall[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_step();
    obs_t got, e;
    vec_t v [12] = '{
      '{16'h0430, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0422, 1'b0, 1'b0, 1'b0},
      '{16'h0430, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0430, 1'b1, 1'b0, 1'b0},
      '{16'h0431, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0430, 1'b0, 1'b0, 1'b0},
      '{16'h0431, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0430, 1'b0, 1'b0, 1'b0},
      '{16'h0431, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0430, 1'b0, 1'b0, 1'b0},
      '{16'h0431, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0430, 1'b0, 1'b0, 1'b0},
      '{16'h0431, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0431, 1'b1, 1'b0, 1'b0},
      '{16'h0500, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0431, 1'b0, 1'b0, 1'b0},
      '{16'h0500, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0431, 1'b0, 1'b0, 1'b0},
      '{16'h07E0, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h07E0, 1'b1, 1'b1, 1'b0},
      '{16'h0050, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1},
      '{16'h0050, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}
    };
    for (int i = 0; i < 12; i++) begin
      apply(v[i]);
      push_exp(v[i]);
      @(posedge clk); #1;
      got = observe();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL step[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t got, e;
    vec_t v [3] = '{
      '{16'h0000, 1'b1, 6'd4, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0440, 1'b1, 1'b0, 1'b0},
      '{16'h0441, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0441, 1'b1, 1'b0, 1'b0},
      '{16'h0007, 1'b0, 6'd0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b1, 1'b0, 1'b0}
    };
    @(negedge clk) rst_n = 1'b0;
    apply('0);
    @(negedge clk) rst_n = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 2; i++) begin
      apply(v[i]);
      push_exp(v[i]);
      @(posedge clk); #1;
      got = observe();
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL async_pre[%0d]: got %s, expected %s", i, fmt(got), fmt(e));
      end
    end
    // Drop rst_n mid-cycle and look before the next rising edge.
    #2 rst_n = 1'b0;
    exp_cnt = '0;
    exp_q.push_back({FETCH_ADDR, 16'd0, 1'b0, 1'b0});
    #1;
    got = observe();
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL async_reset: got %s, expected %s", fmt(got), fmt(e));
    end
    @(negedge clk) rst_n = 1'b1;
    apply(v[2]);
    push_exp(v[2]);
    @(posedge clk); #1;
    got = observe();
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL async_post: got %s, expected %s", fmt(got), fmt(e));
    end
  endtask

  initial begin
    test_reset();
    test_seq_dispatch();
    test_branch();
    test_halt();
    test_stall();
    test_step();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mpc_sequencer.md
Name: mpc_sequencer

Overview:
- Micro-program counter and next-address sequencer for the micro-programmed control unit.
- Drives the 16-bit control-store address into the control memory and consumes that memory's 16-bit next-address field.
- Selects the next address each cycle from four sources: sequential next-address, opcode dispatch, conditional branch, or hold.
- Provides halt, stall and single-step control, plus an instruction-complete pulse.

Parameters:
- ADDR_W, 16, control-store address width.
- OPC_W, 6, opcode field width used for dispatch.
- DISPATCH_BASE, 16'h0400, base address of the per-opcode microroutine table.
- HLT_ADDR, 16'h07E0, microaddress of the HLT routine; reaching it halts the sequencer.
- FETCH_ADDR, 16'h0000, microaddress of the fetch routine (reset and return target).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- next_addr  in  16  next-address field of the current microword.
- dispatch  in  1  current microword ends fetch; jump to the opcode entry.
- opcode  in  6  instruction-register opcode field.
- br_en  in  1  current microword is a conditional branch.
- br_sel  in  2  condition select: 0=Z, 1=C, 2=N, 3=always.
- flag_z, flag_c, flag_n  in  1 each  ALU status flags, already registered.
- stall  in  1  hold the MPC this cycle (memory wait).
- step_mode  in  1  single-step enable.
- step_req  in  1  one-cycle pulse; advances one microword in step mode.
- run_req  in  1  one-cycle pulse; leaves HALT and restarts at FETCH_ADDR.
- mpc_out  out  16  current control-store address.
- halted  out  1  sequencer is in HALT.
- instr_done  out  1  one-cycle pulse when mpc_out loads FETCH_ADDR from a non-fetch address.
- ucycle_cnt  out  16  count of microwords executed (wraps).

Behaviour:
- Reset, asynchronous on rst_n low:
  - mpc_out=FETCH_ADDR, state=RUN, halted=0, instr_done=0, ucycle_cnt=0.
  - Reset mid-operation aborts immediately. There is no partial-update hazard.
- FSM states:
  - RUN: advances every cycle unless stall is high.
  - STEP_WAIT: holds until step_req, then advances once.
  - HALT: holds; halted=1.
- Next-address selection, evaluated once per advance. Priority is highest first:
  - dispatch=1: target = {6'b000001, opcode, 4'b0000}, i.e. DISPATCH_BASE + opcode*16. Example: opcode 2 -> 16'h0420.
  - br_en=1 and condition true: target = next_addr.
  - br_en=1 and condition false: target = mpc_out + 1, wrapping at 16'hFFFF to 0.
  - Otherwise: target = next_addr.
- Advance effects: mpc_out <= target, ucycle_cnt <= ucycle_cnt + 1, single cycle latency.
- Stall: stall=1 blocks the advance in RUN and STEP_WAIT. mpc_out and ucycle_cnt hold. stall takes priority over step_req, so a step_req coincident with stall is dropped.
- Transitions:
  - RUN -> STEP_WAIT when step_mode=1, evaluated before the advance; no advance in that cycle.
  - STEP_WAIT -> RUN when step_mode=0.
  - In STEP_WAIT, step_req=1 and stall=0 advances once and the state stays STEP_WAIT.
  - Any advancing state -> HALT on the cycle mpc_out becomes HLT_ADDR. The HLT microword at HLT_ADDR is presented for exactly that cycle onward; halted rises on the same edge as mpc_out=HLT_ADDR.
  - HALT -> RUN on run_req: mpc_out <= FETCH_ADDR, instr_done pulses, halted drops next cycle.
  - In HALT, step_req, stall and dispatch are ignored.
- instr_done: registered. High for exactly one cycle after an advance whose target is FETCH_ADDR and whose previous mpc_out was not FETCH_ADDR. A self-loop at FETCH_ADDR does not pulse.
- Simultaneous run_req and step_mode in HALT: go to RUN. The step_mode check applies on the following cycle.
- Flags are sampled in the advance cycle only. No internal flag storage.

Decomposition:
- Shared package mcu_pkg holds:
  - FETCH_ADDR, DISPATCH_BASE, HLT_ADDR.
  - br_sel encodings COND_Z, COND_C, COND_N, COND_ALWAYS.
  - FSM state enum seq_state_t {RUN, STEP_WAIT, HALT}.
- One natural sub-module, mpc_next_sel: the combinational next-address mux and condition evaluation. The top level keeps the FSM, registers and counter.

Test Plan:
- Reset then free run with next_addr=16'h0001, then 16'h0000 and dispatch=1, opcode=1 -> mpc_out sequence 0000, 0001, 0410; ucycle_cnt=2.
- At 16'h0540 with br_en=1, br_sel=0: flag_z=1, next_addr=16'h0570 -> mpc_out=16'h0570. Repeat with flag_z=0 -> mpc_out=16'h0541.
- Dispatch opcode 62 -> mpc_out=16'h07E0 and halted=1 on the same edge. Three cycles of toggled inputs -> no change. run_req -> mpc_out=0000, instr_done=1 for one cycle.
- stall held for 3 cycles mid-routine at 16'h0421 -> mpc_out and ucycle_cnt frozen. Release -> advance to next_addr=16'h0422.
- step_mode=1 with step_req pulsed twice, 5 cycles apart -> exactly two advances, and step_req coincident with stall is ignored.
- Assert rst_n low asynchronously mid-cycle while at 16'h0441 -> mpc_out=0000, halted=0, ucycle_cnt=0 before the next clock edge.
